systolic_feeder: RTL and testbench

SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

---
 rtl/systolic_feeder_if.sv | 30 +++
 rtl/systolic_feeder.sv | 155 +++++++++++++++
 tb/tb_systolic_feeder.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_feeder_if.sv
// Purpose: bundles the feeder's vector write handshake and its skewed column outputs.
// Latency: none, this is wiring only.
// Backpressure: in_ready is driven by the feeder (slave) and the producer (master) holds in_valid/in_data until it is accepted.
// Ports: in_valid/in_ready/in_data_0..2 are the write side; out_0..2/out_valid/busy go to the array's top edge.
interface systolic_feeder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data_0;
    logic [WIDTH-1:0] in_data_1;
    logic [WIDTH-1:0] in_data_2;
    logic [WIDTH-1:0] out_0;
    logic [WIDTH-1:0] out_1;
    logic [WIDTH-1:0] out_2;
    logic [2:0]       out_valid;
    logic             busy;

    // Producer / environment side.
    modport master (
        output in_valid, in_data_0, in_data_1, in_data_2,
        input  in_ready, out_0, out_1, out_2, out_valid, busy
    );

    // Feeder side.
    modport slave (
        input  in_valid, in_data_0, in_data_1, in_data_2,
        output in_ready, out_0, out_1, out_2, out_valid, busy
    );
endinterface

// File: rtl/systolic_feeder.sv
// Purpose: ping-pong buffers 3-element vectors and drains each full bank as three column streams, lane k skewed by k cycles.
// Latency: out_valid[0] rises 2 cycles after the edge that fills a bank when the drain side is idle; lane k lags lane 0 by k.
// Backpressure: in_ready = !full[wr_bank], so the write side stalls only while both banks hold undrained data.
// Ports: clk, rst (async active-low), bus (systolic_feeder_if.slave).
module systolic_feeder #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    systolic_feeder_if.slave  bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 2);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    // The drain runs DEPTH+2 steps so lane 2 can emit its last element two steps after lane 0.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH + 1);

    typedef enum logic {IDLE, DRAIN} state_t;

    // Bank memory holds no reset: contents are only read after being written.
    logic [WIDTH-1:0] mem [2][DEPTH][3];

    logic [1:0]       full;
    logic             wr_bank;
    logic [PTR_W-1:0] wr_ptr;
    logic             wr_fire;
    logic             wr_last;

    state_t           state, state_nxt;
    logic             rd_bank, rd_bank_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             release_bank;

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    assign bus.in_ready = !full[wr_bank];
    assign wr_fire      = bus.in_valid && bus.in_ready;
    assign wr_last      = (wr_ptr == PTR_LAST);

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_bank][wr_ptr][0] <= bus.in_data_0;
            mem[wr_bank][wr_ptr][1] <= bus.in_data_1;
            mem[wr_bank][wr_ptr][2] <= bus.in_data_2;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_bank <= 1'b0;
            wr_ptr  <= '0;
        end else if (wr_fire) begin
            if (wr_last) begin
                wr_ptr  <= '0;
                wr_bank <= ~wr_bank;
            end else begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
        end
    end

    // Filling and releasing always target different banks (a full bank is
    // never written), so both updates can land on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full <= '0;
        end else begin
            if (release_bank)
                full[rd_bank] <= 1'b0;
            if (wr_fire && wr_last)
                full[wr_bank] <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Drain FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            rd_bank <= 1'b0;
            cnt     <= '0;
        end else begin
            state   <= state_nxt;
            rd_bank <= rd_bank_nxt;
            cnt     <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        rd_bank_nxt  = rd_bank;
        cnt_nxt      = cnt;
        release_bank = 1'b0;
        case (state)
            IDLE: begin
                if (full[rd_bank]) begin
                    state_nxt = DRAIN;
                    cnt_nxt   = '0;
                end
            end
            DRAIN: begin
                if (cnt == CNT_LAST) begin
                    release_bank = 1'b1;
                    rd_bank_nxt  = ~rd_bank;
                    cnt_nxt      = '0;
                    // Chain straight into the other bank when it is already
                    // waiting, so consecutive banks stream without a gap.
                    state_nxt    = full[~rd_bank] ? DRAIN : IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.busy = (state == DRAIN);

    // ------------------------------------------------------------------
    // Skewed output lanes: lane k reads row (cnt - k) while it is in range.
    // ------------------------------------------------------------------
    for (genvar k = 0; k < 3; k++) begin : g_lane
        logic [CNT_W-1:0] age;
        logic [PTR_W-1:0] rd_idx;
        logic             vld;
        logic [WIDTH-1:0] dat;
        logic             vld_q;
        logic [WIDTH-1:0] dat_q;

        always_comb begin
            age    = cnt - CNT_W'(k);
            rd_idx = age[PTR_W-1:0];
            vld    = (state == DRAIN) && (cnt >= CNT_W'(k)) && (age < CNT_W'(DEPTH));
            dat    = vld ? mem[rd_bank][rd_idx][k] : '0;
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                vld_q <= 1'b0;
                dat_q <= '0;
            end else begin
                vld_q <= vld;
                dat_q <= dat;
            end
        end
    end

    assign bus.out_0     = g_lane[0].dat_q;
    assign bus.out_1     = g_lane[1].dat_q;
    assign bus.out_2     = g_lane[2].dat_q;
    assign bus.out_valid = {g_lane[2].vld_q, g_lane[1].vld_q, g_lane[0].vld_q};
endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: directed phases with random data, checked against a bank-level timing and data model.
module tb_systolic_feeder;
    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    typedef logic [2:0][WIDTH-1:0] vec_t;

    logic clk;
    logic rst;

    systolic_feeder_if #(.WIDTH(WIDTH)) bus ();
    systolic_feeder #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   accepted = 0;
    int   lane_cnt [3];
    int   comp_cyc [64];
    vec_t vec_hist [$];
    bit   last_fire;
    bit   saw_not_ready;
    bit   prev_busy;
    int   busy_falls;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // First lane-0 output cycle of bank b: a bank starts two cycles after it
    // fills, but never before the cycle after the previous bank is released.
    function automatic int start_of(int b);
        int s = 0;
        int rel = -1000;
        for (int bb = 0; bb <= b; bb++) begin
            s   = (comp_cyc[bb] + 2 > rel + 1) ? comp_cyc[bb] + 2 : rel + 1;
            rel = s + DEPTH + 1;
        end
        return s;
    endfunction

    function automatic int exp_cycle(int g, int k);
        if (g / DEPTH >= accepted / DEPTH) return -1;
        return start_of(g / DEPTH) + (g % DEPTH) + k;
    endfunction

    function automatic bit busy_model();
        bit b = 1'b0;
        int s;
        for (int bb = 0; bb < accepted / DEPTH; bb++) begin
            s = start_of(bb);
            if (cyc >= s - 1 && cyc <= s + DEPTH) b = 1'b1;
        end
        return b;
    endfunction

    function automatic logic [WIDTH-1:0] lane_out(int k);
        case (k)
            0:       return bus.out_0;
            1:       return bus.out_1;
            default: return bus.out_2;
        endcase
    endfunction

    task automatic model_reset();
        accepted = 0;
        for (int k = 0; k < 3; k++) lane_cnt[k] = 0;
        vec_hist.delete();
        prev_busy = 1'b0;
    endtask

    // One clock: check in_ready, advance, then score every lane and busy.
    task automatic tick();
        bit               fire;
        vec_t             v;
        int               g;
        logic [WIDTH-1:0] o;
        fire = bus.in_valid && bus.in_ready;
        chk("in_ready", 32'(bus.in_ready),
            32'(((accepted / DEPTH) - (lane_cnt[2] / DEPTH)) < 2));
        if (!bus.in_ready) saw_not_ready = 1'b1;
        v = {bus.in_data_2, bus.in_data_1, bus.in_data_0};
        @(posedge clk);
        #1;
        cyc++;
        if (fire) begin
            vec_hist.push_back(v);
            accepted++;
            if (accepted % DEPTH == 0) comp_cyc[accepted / DEPTH - 1] = cyc;
        end
        for (int k = 0; k < 3; k++) begin
            o = lane_out(k);
            if (bus.out_valid[k]) begin
                g = lane_cnt[k];
                chk("lane_overrun", 32'(g < vec_hist.size()), 32'd1);
                if (g < vec_hist.size()) begin
                    chk("lane_data", o, vec_hist[g][k]);
                    chk("lane_time", 32'(cyc), 32'(exp_cycle(g, k)));
                end
                lane_cnt[k]++;
            end else begin
                chk("idle_zero", o, '0);
            end
        end
        chk("busy", 32'(bus.busy), 32'(busy_model()));
        if (prev_busy && !bus.busy) busy_falls++;
        prev_busy = bus.busy;
        last_fire = fire;
    endtask

    task automatic set_data(int mode, int idx);
        if (mode == 2) begin
            bus.in_data_0 = WIDTH'(10 * idx + 0);
            bus.in_data_1 = WIDTH'(10 * idx + 1);
            bus.in_data_2 = WIDTH'(10 * idx + 2);
        end else begin
            bus.in_data_0 = $urandom;
            bus.in_data_1 = $urandom;
            bus.in_data_2 = $urandom;
        end
    endtask

    // mode 0: in_valid held high, random data; 1: random in_valid; 2: fixed pattern 10i+k.
    task automatic send(int n, int mode);
        int sent = 0;
        int budget = 0;
        set_data(mode, 0);
        while (sent < n && budget < 500) begin
            bus.in_valid = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            if (last_fire) begin
                sent++;
                set_data(mode, sent);
            end
            budget++;
        end
        bus.in_valid = 1'b0;
        chk("send_count", 32'(sent), 32'(n));
    endtask

    task automatic wait_drain();
        int n = 0;
        while (!(lane_cnt[2] == accepted && lane_cnt[0] == accepted && !bus.busy) && n < 200) begin
            tick();
            n++;
        end
        chk("drain_timeout", 32'(n < 200), 32'd1);
        tick();
    endtask

    logic [2:0] pat [8];
    int         base;
    int         n_wait;

    initial begin
        pat = '{3'b000, 3'b001, 3'b011, 3'b111, 3'b111, 3'b110, 3'b100, 3'b000};
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data_0 = '0;
        bus.in_data_1 = '0;
        bus.in_data_2 = '0;
        model_reset();
        busy_falls    = 0;
        saw_not_ready = 1'b0;

        #3;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_0", bus.out_0, '0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Single bank with the 10i+k pattern and the exact valid staircase.
        send(4, 2);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("ov_pattern", 32'(bus.out_valid), 32'(pat[i]));
        end
        wait_drain();

        // Eight back-to-back vectors: no stall, banks drain without a gap.
        saw_not_ready = 1'b0;
        busy_falls    = 0;
        send(8, 0);
        chk("rdy_held", 32'(saw_not_ready), 32'd0);
        wait_drain();
        chk("busy_gapfree", 32'(busy_falls), 32'd1);

        // Twelve vectors flooded: in_ready must drop while both banks are full.
        saw_not_ready = 1'b0;
        send(12, 0);
        chk("rdy_dropped", 32'(saw_not_ready), 32'd1);
        wait_drain();

        // Reset in the middle of a drain (cnt=2) with the other bank part-filled.
        base = lane_cnt[0];
        send(7, 0);
        n_wait = 0;
        while (lane_cnt[0] < base + 2 && n_wait < 50) begin
            tick();
            n_wait++;
        end
        chk("mid_drain_reached", 32'(lane_cnt[0]), 32'(base + 2));
        chk("mid_drain_busy", 32'(bus.busy), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("mid_rst_out_1", bus.out_1, '0);
        #1;
        rst = 1'b1;
        model_reset();
        send(4, 1);
        wait_drain();

        // Random in_valid over many vectors: order and skew per lane.
        send(40, 1);
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
